// File: rtl/bp_pkg.sv
// Shared constants and counter helpers for the pattern-history-table
// branch predictor.
package bp_pkg;

    localparam int MODE_BIMODAL = 0;
    localparam int MODE_GSHARE  = 1;

    // Saturating step of a counter of cnt_w bits (1..4), never wraps.
    function automatic logic [3:0] sat_next(
        input logic [3:0] cnt,
        input logic       taken,
        input int         cnt_w
    );
        logic [3:0] cmax;
        cmax = 4'((1 << cnt_w) - 1);
        if (taken && (cnt < cmax)) return cnt + 4'd1;
        if (!taken && (cnt != 4'd0)) return cnt - 4'd1;
        return cnt;
    endfunction

    // Weakly-taken reset value: 2**(cnt_w-1).
    function automatic logic [3:0] cnt_init(input int cnt_w);
        return 4'(1 << (cnt_w - 1));
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Counter array of the predictor: one write port, one read port.
// The read port returns the post-write value on a same-index hit.
module bp_pht #(
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int IW    = (IDX_W > 0) ? IDX_W : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic             wr_taken,
    input  logic [IW-1:0]    rd_idx,
    output logic [CNT_W-1:0] rd_cnt
);
    import bp_pkg::*;

    localparam int DEPTH = 1 << IDX_W;

    logic [CNT_W-1:0] cnt_q [DEPTH];
    logic [CNT_W-1:0] cnt_d [DEPTH];

    // Apply the saturating update to the addressed entry only.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_en && (wr_idx == IW'(i))) begin
                cnt_d[i] = CNT_W'(sat_next(4'(cnt_q[i]), wr_taken, CNT_W));
            end
        end
    end

    // Read from next-state so a same-cycle write is seen (bypass).
    always_comb begin
        rd_cnt = cnt_d[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IW'(i)) rd_cnt = cnt_d[i];
        end
    end

    // Counter storage, initialised to weakly taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= CNT_W'(cnt_init(CNT_W));
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/bp_pht_predictor.sv
// Bimodal / gshare branch direction predictor: index hashing, global
// history, registered prediction outputs and update statistics.
module bp_pht_predictor #(
    parameter int PC_W   = 32,
    parameter int PC_LSB = 2,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int MODE   = 0,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lkp_valid,
    input  logic [PC_W-1:0]   lkp_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic              pred_strong,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_mispred,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispred
);
    import bp_pkg::*;

    localparam int IW = (IDX_W > 0) ? IDX_W : 1;
    localparam logic [STAT_W-1:0] SMAX = '1;

    logic [IW-1:0]    ghr_q, ghr_d, hist;
    logic [IW-1:0]    idx_l, idx_u;
    logic [CNT_W-1:0] rd_cnt;
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             pred_strong_q, pred_strong_d;
    logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
    logic [STAT_W-1:0] stat_mis_q, stat_mis_d;
    logic             unused_pc;

    // PC bits outside the index slice are deliberately ignored.
    assign unused_pc = ^{lkp_pc, upd_pc};

    // Index hashing; both ports see the pre-update history.
    always_comb begin
        hist  = (MODE == MODE_GSHARE) ? ghr_q : '0;
        idx_l = lkp_pc[PC_LSB +: IW] ^ hist;
        idx_u = upd_pc[PC_LSB +: IW] ^ hist;
        if (IDX_W == 0) begin
            idx_l = '0;
            idx_u = '0;
        end
    end

    bp_pht #(
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) u_pht (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (upd_valid),
        .wr_idx   (idx_u),
        .wr_taken (upd_taken),
        .rd_idx   (idx_l),
        .rd_cnt   (rd_cnt)
    );

    // Non-speculative history: shift in resolved outcomes.
    always_comb begin
        ghr_d = ghr_q;
        if ((MODE == MODE_GSHARE) && (IDX_W > 0) && upd_valid) begin
            ghr_d = IW'({ghr_q, upd_taken});
        end
    end

    // Prediction outputs hold their last value between lookups.
    always_comb begin
        pred_valid_d  = lkp_valid;
        pred_taken_d  = pred_taken_q;
        pred_strong_d = pred_strong_q;
        if (lkp_valid) begin
            pred_taken_d  = rd_cnt[CNT_W-1];
            pred_strong_d = (rd_cnt == '0) || (rd_cnt == '1);
        end
    end

    // Saturating statistics; clear wins over a same-cycle update.
    always_comb begin
        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (stat_clr) begin
            stat_upd_d = '0;
            stat_mis_d = '0;
        end else if (upd_valid) begin
            if (stat_upd_q != SMAX) stat_upd_d = stat_upd_q + 1'b1;
            if (upd_mispred && (stat_mis_q != SMAX)) begin
                stat_mis_d = stat_mis_q + 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b1;
            pred_strong_q <= 1'b0;
            stat_upd_q    <= '0;
            stat_mis_q    <= '0;
        end else begin
            ghr_q         <= ghr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_strong_q <= pred_strong_d;
            stat_upd_q    <= stat_upd_d;
            stat_mis_q    <= stat_mis_d;
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_taken_q;
    assign pred_strong  = pred_strong_q;
    assign stat_updates = stat_upd_q;
    assign stat_mispred = stat_mis_q;

endmodule

// File: tb/tb_bp_pht_predictor.sv
// Bench for bp_pht_predictor: four configurations driven in parallel,
// a direct vector table, corner sequences and a random model check.
module tb_bp_pht_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        lv, uv, ut, um, clr;
    logic [31:0] lpc, upc;
    logic [3:0]  pv, pt, ps;
    logic [15:0] su0, sm0, su1, sm1, su3, sm3;
    logic [1:0]  su2, sm2;

    int checks = 0;
    int errors = 0;

    // d0 bimodal default, d1 gshare, d2 narrow stats, d3 single 1-bit entry
    localparam int IDXW [4] = '{6, 6, 6, 0};
    localparam int CNTW [4] = '{2, 2, 2, 1};
    localparam int MODEV[4] = '{0, 1, 0, 0};
    localparam int STATW[4] = '{16, 16, 2, 16};

    bp_pht_predictor d0 (
        .clk(clk), .rst_n(rst_n), .lkp_valid(lv), .lkp_pc(lpc),
        .pred_valid(pv[0]), .pred_taken(pt[0]), .pred_strong(ps[0]),
        .upd_valid(uv), .upd_pc(upc), .upd_taken(ut), .upd_mispred(um),
        .stat_clr(clr), .stat_updates(su0), .stat_mispred(sm0));

    bp_pht_predictor #(.MODE(1)) d1 (
        .clk(clk), .rst_n(rst_n), .lkp_valid(lv), .lkp_pc(lpc),
        .pred_valid(pv[1]), .pred_taken(pt[1]), .pred_strong(ps[1]),
        .upd_valid(uv), .upd_pc(upc), .upd_taken(ut), .upd_mispred(um),
        .stat_clr(clr), .stat_updates(su1), .stat_mispred(sm1));

    bp_pht_predictor #(.STAT_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .lkp_valid(lv), .lkp_pc(lpc),
        .pred_valid(pv[2]), .pred_taken(pt[2]), .pred_strong(ps[2]),
        .upd_valid(uv), .upd_pc(upc), .upd_taken(ut), .upd_mispred(um),
        .stat_clr(clr), .stat_updates(su2), .stat_mispred(sm2));

    bp_pht_predictor #(.CNT_W(1), .IDX_W(0)) d3 (
        .clk(clk), .rst_n(rst_n), .lkp_valid(lv), .lkp_pc(lpc),
        .pred_valid(pv[3]), .pred_taken(pt[3]), .pred_strong(ps[3]),
        .upd_valid(uv), .upd_pc(upc), .upd_taken(ut), .upd_mispred(um),
        .stat_clr(clr), .stat_updates(su3), .stat_mispred(sm3));

    // Reference model: plain integer counters per configuration.
    int mc [4][64];
    int mg [4];
    int mpv[4], mpt[4], mps[4], msu[4], msm[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 64; i++) mc[k][i] = 1 << (CNTW[k] - 1);
            mg[k] = 0; mpv[k] = 0; mpt[k] = 1; mps[k] = 0;
            msu[k] = 0; msm[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            int mask, cmax, smax, g, iu, il, c;
            mask = (1 << IDXW[k]) - 1;
            cmax = (1 << CNTW[k]) - 1;
            smax = (1 << STATW[k]) - 1;
            g = (MODEV[k] == 1) ? mg[k] : 0;
            if (uv) begin
                iu = (int'(upc >> 2) & mask) ^ g;
                if (ut && mc[k][iu] < cmax) mc[k][iu]++;
                else if (!ut && mc[k][iu] > 0) mc[k][iu]--;
                if (MODEV[k] == 1) mg[k] = ((mg[k] << 1) | int'(ut)) & mask;
            end
            mpv[k] = int'(lv);
            if (lv) begin
                il = (int'(lpc >> 2) & mask) ^ g;
                c = mc[k][il];
                mpt[k] = (c >= (1 << (CNTW[k] - 1))) ? 1 : 0;
                mps[k] = (c == 0 || c == cmax) ? 1 : 0;
            end
            if (clr) begin
                msu[k] = 0; msm[k] = 0;
            end else if (uv) begin
                if (msu[k] < smax) msu[k]++;
                if (um && msm[k] < smax) msm[k]++;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        int asu[4], asm[4];
        asu = '{int'(su0), int'(su1), int'(su2), int'(su3)};
        asm = '{int'(sm0), int'(sm1), int'(sm2), int'(sm3)};
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("d%0d.pred_valid", k), int'(pv[k]), mpv[k]);
            chk($sformatf("d%0d.pred_taken", k), int'(pt[k]), mpt[k]);
            chk($sformatf("d%0d.pred_strong", k), int'(ps[k]), mps[k]);
            chk($sformatf("d%0d.stat_updates", k), asu[k], msu[k]);
            chk($sformatf("d%0d.stat_mispred", k), asm[k], msm[k]);
        end
    endtask

    task automatic idle();
        lv = 0; uv = 0; ut = 0; um = 0; clr = 0; lpc = '0; upc = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic m);
        uv = 1; upc = pc; ut = t; um = m;
    endtask

    typedef struct {
        logic        lv;
        logic [31:0] lpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut, um, clr;
        int          pv, pt, ps, su, sm;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, 32'h40,   0, 32'h0,   0, 0, 0, 1, 1, 0, 0, 0};
        tbl[1]  = '{0, 32'h0,    1, 32'h40,  0, 0, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{0, 32'h0,    1, 32'h40,  0, 1, 0, 0, 1, 0, 2, 1};
        tbl[3]  = '{0, 32'h0,    1, 32'h40,  0, 0, 0, 0, 1, 0, 3, 1};
        tbl[4]  = '{1, 32'h40,   0, 32'h0,   0, 0, 0, 1, 0, 1, 3, 1};
        tbl[5]  = '{1, 32'h44,   1, 32'h44,  0, 0, 0, 1, 0, 0, 4, 1};
        tbl[6]  = '{1, 32'h80,   0, 32'h0,   0, 0, 0, 1, 1, 0, 4, 1};
        tbl[7]  = '{1, 32'h1040, 1, 32'h140, 1, 0, 0, 1, 0, 0, 5, 1};
        tbl[8]  = '{1, 32'h48,   1, 32'h40,  1, 0, 0, 1, 1, 0, 6, 1};
        tbl[9]  = '{1, 32'h40,   1, 32'h40,  1, 0, 0, 1, 1, 1, 7, 1};
        tbl[10] = '{0, 32'h0,    1, 32'h40,  1, 1, 1, 0, 1, 1, 0, 0};
        tbl[11] = '{1, 32'h40,   1, 32'h44,  1, 1, 0, 1, 1, 1, 1, 1};

        // Reset state of every configuration
        do_reset();
        check_all();

        // Vector table on the default bimodal instance
        for (int i = 0; i < 12; i++) begin
            lv = tbl[i].lv; lpc = tbl[i].lpc;
            uv = tbl[i].uv; upc = tbl[i].upc;
            ut = tbl[i].ut; um = tbl[i].um; clr = tbl[i].clr;
            cyc();
            chk($sformatf("vec%0d.pred_valid", i), int'(pv[0]), tbl[i].pv);
            chk($sformatf("vec%0d.pred_taken", i), int'(pt[0]), tbl[i].pt);
            chk($sformatf("vec%0d.pred_strong", i), int'(ps[0]), tbl[i].ps);
            chk($sformatf("vec%0d.stat_updates", i), int'(su0), tbl[i].su);
            chk($sformatf("vec%0d.stat_mispred", i), int'(sm0), tbl[i].sm);
        end
        idle();

        // gshare history: outcomes 1,1,0 give ghr 6'b000110
        do_reset();
        upd(32'h0, 1, 0); cyc();
        upd(32'h0, 1, 0); cyc();
        upd(32'h0, 0, 0); cyc();
        idle(); lv = 1; lpc = 32'h18; cyc();
        chk("gshare.idx0.taken", int'(pt[1]), 1);
        chk("gshare.idx0.strong", int'(ps[1]), 1);
        lpc = 32'h14; cyc();
        chk("gshare.idx3.taken", int'(pt[1]), 0);
        chk("gshare.idx3.strong", int'(ps[1]), 0);
        idle();

        // 2-bit statistics saturate, clear beats concurrent update
        do_reset();
        for (int i = 0; i < 5; i++) begin
            upd(32'h20, i[0], (i < 2) ? 1'b1 : 1'b0);
            cyc();
        end
        chk("stat2.updates.sat", int'(su2), 3);
        chk("stat2.mispred", int'(sm2), 2);
        upd(32'h20, 1, 1); clr = 1; cyc();
        chk("stat2.clr.updates", int'(su2), 0);
        chk("stat2.clr.mispred", int'(sm2), 0);
        clr = 0; cyc();
        chk("stat2.after.updates", int'(su2), 1);
        chk("stat2.after.mispred", int'(sm2), 1);
        idle();

        // Single 1-bit entry: prediction follows the previous outcome
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(); upd(32'h100 * i, i[0], 0); cyc();
            idle(); lv = 1; lpc = $urandom; cyc();
            chk($sformatf("onebit%0d.taken", i), int'(pt[3]), int'(i[0]));
            chk($sformatf("onebit%0d.strong", i), int'(ps[3]), 1);
        end
        idle();

        // Asynchronous reset during a lookup
        do_reset();
        upd(32'h14, 0, 0); cyc();
        cyc();
        idle(); lv = 1; lpc = 32'h14; cyc();
        chk("rst.pre.valid", int'(pv[0]), 1);
        chk("rst.pre.taken", int'(pt[0]), 0);
        rst_n = 1'b0;
        #1;
        chk("rst.async.valid", int'(pv[0]), 0);
        chk("rst.async.taken", int'(pt[0]), 1);
        chk("rst.async.strong", int'(ps[0]), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst.release.valid", int'(pv[0]), 0);
        cyc();
        chk("rst.post.valid", int'(pv[0]), 1);
        chk("rst.post.taken", int'(pt[0]), 1);
        chk("rst.post.strong", int'(ps[0]), 0);
        check_all();

        // Random traffic with frequent index collisions
        for (int n = 0; n < 600; n++) begin
            lv  = $urandom_range(0, 1);
            uv  = $urandom_range(0, 1);
            ut  = $urandom_range(0, 1);
            um  = $urandom_range(0, 1);
            clr = ($urandom_range(0, 31) == 0);
            lpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            upc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2)
                | 32'($urandom_range(0, 3));
            cyc();
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
